conv_slice_feeder: RTL and testbench

//  Transmit side of the conv_buffer slice interface. Raster-scans an image held in a

---
 rtl/conv_slice_feeder_if.sv | 36 +++
 rtl/conv_slice_feeder.sv | 151 +++++++++++++++
 tb/tb_conv_slice_feeder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/conv_slice_feeder_if.sv
// Slice-feeder bus: control inputs, the single-port RAM read port and the
// conv_buffer slice/window outputs, grouped for the feeder (master) and its environment.
interface conv_slice_feeder_if #(
  parameter int DAT_W  = 8,
  parameter int SLICE  = 3,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int ADDR_W = 10
);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  logic                     start;
  logic                     stall;
  logic                     mem_ren;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DAT_W-1:0]         mem_rdata;
  logic                     wen;
  logic                     pop;
  logic [DAT_W*SLICE-1:0]   wdata;
  logic                     win_valid;
  logic [ROW_W-1:0]         win_row;
  logic [COL_W-1:0]         win_col;
  logic                     busy;
  logic                     done;

  modport master (
    input  start, stall, mem_rdata,
    output mem_ren, mem_addr, wen, pop, wdata, win_valid, win_row, win_col, busy, done
  );

  modport slave (
    output start, stall, mem_rdata,
    input  mem_ren, mem_addr, wen, pop, wdata, win_valid, win_row, win_col, busy, done
  );
endinterface

// File: rtl/conv_slice_feeder.sv
// Raster-scans an image in a 1-cycle-latency RAM, gathers one vertical SLICE-pixel
// column at a time, hands it to the conv_buffer (wen then pop) and flags full windows.
module conv_slice_feeder #(
  parameter int DAT_W  = 8,
  parameter int SLICE  = 3,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  conv_slice_feeder_if.master   bus
);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);
  localparam int K_W   = $clog2(SLICE);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] COL_WIN0 = COL_W'(SLICE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - SLICE);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(SLICE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_WEN, S_POP, S_ADV, S_DONE
  } state_t;

  typedef logic [SLICE-1:0][DAT_W-1:0] slice_t;

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row0_q, row0_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [K_W-1:0]    k_q, k_d;
  logic              rd_valid_q, rd_valid_d;
  logic [K_W-1:0]    rd_lane_q, rd_lane_d;
  slice_t            stage_q, stage_d;
  slice_t            wdata_q, wdata_d;
  logic              win_valid_q, win_valid_d;
  logic [ROW_W-1:0]  win_row_q, win_row_d;
  logic [COL_W-1:0]  win_col_q, win_col_d;
  logic [ADDR_W-1:0] rd_addr;

  // NOTE: sequential state uses non-blocking assignments only; blocking here would
  // let downstream flops in the same edge see the new value and collapse pipeline stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_FETCH;
      S_FETCH: if (k_q == K_LAST) state_d = S_LOAD;
      S_LOAD:  state_d = S_WEN;
      S_WEN:   state_d = S_POP;
      S_POP:   state_d = S_ADV;
      S_ADV: begin
        if (!bus.stall) begin
          if (col_q != COL_LAST || row0_q != ROW_LAST) state_d = S_FETCH;
          else                                         state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_addr = (ADDR_W'(row0_q) + ADDR_W'(k_q)) * ADDR_W'(IMG_W) + ADDR_W'(col_q);

  always_comb begin
    bus.mem_ren  = (state_q == S_FETCH);
    bus.mem_addr = (state_q == S_FETCH) ? rd_addr : '0;
    bus.wen      = (state_q == S_WEN);
    bus.pop      = (state_q == S_POP);
    bus.busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    bus.done     = (state_q == S_DONE);
  end

  // Lanes 0..SLICE-2 collect in stage_q; wdata_q is refreshed only at the end of LOAD
  // so the slice seen by the buffer holds steady while the next column is fetched.
  always_comb begin
    row0_d      = row0_q;
    col_d       = col_q;
    k_d         = '0;
    rd_valid_d  = (state_q == S_FETCH);
    rd_lane_d   = k_q;
    stage_d     = stage_q;
    wdata_d     = wdata_q;
    win_valid_d = 1'b0;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;

    if (state_q == S_IDLE && bus.start) begin
      row0_d = '0;
      col_d  = '0;
    end
    if (state_q == S_FETCH && k_q != K_LAST) k_d = k_q + K_W'(1);
    if (rd_valid_q) stage_d[rd_lane_q] = bus.mem_rdata;
    if (state_q == S_LOAD) begin
      wdata_d          = stage_q;
      wdata_d[SLICE-1] = bus.mem_rdata;
    end
    if (state_q == S_POP && col_q >= COL_WIN0) begin
      win_valid_d = 1'b1;
      win_row_d   = row0_q;
      win_col_d   = col_q - COL_WIN0;
    end
    if (state_q == S_ADV && !bus.stall) begin
      if (col_q != COL_LAST) begin
        col_d = col_q + COL_W'(1);
      end else if (row0_q != ROW_LAST) begin
        col_d  = '0;
        row0_d = row0_q + ROW_W'(1);
      end
    end
  end

  // NOTE: the slice registers are ordinary flops, so they are cleared on reset to keep
  // wdata at zero and drop any partially gathered column.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row0_q      <= '0;
      col_q       <= '0;
      k_q         <= '0;
      rd_valid_q  <= 1'b0;
      rd_lane_q   <= '0;
      stage_q     <= '0;
      wdata_q     <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      row0_q      <= row0_d;
      col_q       <= col_d;
      k_q         <= k_d;
      rd_valid_q  <= rd_valid_d;
      rd_lane_q   <= rd_lane_d;
      stage_q     <= stage_d;
      wdata_q     <= wdata_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

  assign bus.wdata     = wdata_q;
  assign bus.win_valid = win_valid_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;
endmodule

// File: tb/tb_conv_slice_feeder.sv
// Directed bench for conv_slice_feeder on a 4x4 image with RAM[a]=a and 3-pixel slices.
module tb_conv_slice_feeder;
  localparam int DAT_W  = 8;
  localparam int SLICE  = 3;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int ADDR_W = 4;

  logic clk;
  logic rst;

  conv_slice_feeder_if #(.DAT_W(DAT_W), .SLICE(SLICE), .IMG_W(IMG_W), .IMG_H(IMG_H),
                         .ADDR_W(ADDR_W)) bus ();

  conv_slice_feeder #(.DAT_W(DAT_W), .SLICE(SLICE), .IMG_W(IMG_W), .IMG_H(IMG_H),
                      .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: contents equal the address, one cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_ren) bus.mem_rdata <= DAT_W'(bus.mem_addr);
  end

  typedef struct {
    int row0;
    int col;
    int a0, a1, a2;
    int wdata;
    bit win;
    int win_row;
    int win_col;
    int stall;
    bit start_pulse;
  } col_vec_t;

  col_vec_t vecs[8];
  int n_vec = 0;
  int n_bad = 0;
  int cur_row = 0;
  int cur_col = 0;

  int n_wen = 0;
  int n_pop = 0;
  int n_win = 0;
  int n_overlap = 0;

  always @(negedge clk) begin
    if (bus.wen)             n_wen++;
    if (bus.pop)             n_pop++;
    if (bus.win_valid)       n_win++;
    if (bus.wen && bus.pop)  n_overlap++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (row0=%0d col=%0d): got %0h expected %0h",
               name, cur_row, cur_col, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_mem_ren"},   bus.mem_ren,   0);
    check({tag, "_mem_addr"},  bus.mem_addr,  0);
    check({tag, "_wen"},       bus.wen,       0);
    check({tag, "_pop"},       bus.pop,       0);
    check({tag, "_wdata"},     bus.wdata,     0);
    check({tag, "_win_valid"}, bus.win_valid, 0);
    check({tag, "_win_row"},   bus.win_row,   0);
    check({tag, "_win_col"},   bus.win_col,   0);
    check({tag, "_busy"},      bus.busy,      0);
    check({tag, "_done"},      bus.done,      0);
  endtask

  // Entered at the first FETCH cycle of the column; leaves at the cycle after ADV.
  task automatic run_column(input col_vec_t v, input bit mods);
    int exp_a[3];
    exp_a = '{v.a0, v.a1, v.a2};
    cur_row = v.row0;
    cur_col = v.col;
    for (int k = 0; k < 3; k++) begin
      bus.start = (mods && v.start_pulse && k == 0);
      check("fetch_ren",  bus.mem_ren, 1);
      check("fetch_addr", bus.mem_addr, exp_a[k]);
      check("fetch_quiet", {bus.wen, bus.pop}, 0);
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("load_quiet", {bus.mem_ren, bus.wen, bus.pop}, 0);
    @(negedge clk);
    check("wen_ctrl",  {bus.mem_ren, bus.wen, bus.pop}, 3'b010);
    check("wen_wdata", bus.wdata, v.wdata);
    @(negedge clk);
    check("pop_ctrl",  {bus.mem_ren, bus.wen, bus.pop}, 3'b001);
    check("pop_wdata", bus.wdata, v.wdata);
    check("pop_busy",  bus.busy, 1);
    @(negedge clk);
    check("adv_win_valid", bus.win_valid, v.win);
    if (v.win) begin
      check("adv_win_row", bus.win_row, v.win_row);
      check("adv_win_col", bus.win_col, v.win_col);
    end
    if (mods && v.stall > 0) begin
      bus.stall = 1'b1;
      for (int s = 0; s < v.stall; s++) begin
        @(negedge clk);
        check("stall_no_repulse", bus.win_valid, 0);
        check("stall_quiet", {bus.mem_ren, bus.wen, bus.pop}, 0);
        check("stall_wdata", bus.wdata, v.wdata);
      end
      bus.stall = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic run_scan(input bit mods);
    int b_wen, b_pop, b_win, b_ovl;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("scan_busy_after_start", bus.busy, 1);
    b_wen = n_wen;
    b_pop = n_pop;
    b_win = n_win;
    b_ovl = n_overlap;
    for (int i = 0; i < 8; i++) run_column(vecs[i], mods);
    check("done_pulse", bus.done, 1);
    check("done_busy",  bus.busy, 0);
    check("done_quiet", {bus.mem_ren, bus.wen, bus.pop}, 0);
    check("count_wen",     n_wen - b_wen, 8);
    check("count_pop",     n_pop - b_pop, 8);
    check("count_win",     n_win - b_win, 4);
    check("count_overlap", n_overlap - b_ovl, 0);
    @(negedge clk);
    check("after_done_pulse", bus.done, 0);
    check("after_done_busy",  bus.busy, 0);
  endtask

  initial begin
    //          row0 col  a0 a1 a2  wdata      win r  c  stall start
    vecs[0] = '{0,   0,   0, 4, 8,  'h080400,  0,  0, 0, 0,    0};
    vecs[1] = '{0,   1,   1, 5, 9,  'h090501,  0,  0, 0, 0,    0};
    vecs[2] = '{0,   2,   2, 6, 10, 'h0a0602,  1,  0, 0, 5,    0};
    vecs[3] = '{0,   3,   3, 7, 11, 'h0b0703,  1,  0, 1, 0,    0};
    vecs[4] = '{1,   0,   4, 8, 12, 'h0c0804,  0,  0, 0, 0,    1};
    vecs[5] = '{1,   1,   5, 9, 13, 'h0d0905,  0,  0, 0, 0,    0};
    vecs[6] = '{1,   2,   6, 10, 14, 'h0e0a06, 1,  1, 0, 0,    0};
    vecs[7] = '{1,   3,   7, 11, 15, 'h0f0b07, 1,  1, 1, 0,    0};

    rst = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b1;
    @(negedge clk);
    check_idle("idle");

    // Full scan with a 5-cycle stall at the first window and a start pulse mid-scan.
    run_scan(1'b1);

    // Abort during the second column's WEN cycle.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    run_column(vecs[0], 1'b0);
    cur_row = 0;
    cur_col = 1;
    repeat (4) @(negedge clk);
    check("abort_in_wen", bus.wen, 1);
    #2 rst = 1'b0;
    #1 check_idle("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    // Fresh scan after the abort must reproduce the clean sequence.
    run_scan(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
